// File: rtl/arb_pkg.sv
// Shared types and address helpers for the arbitrator bus initiator.
package arb_pkg;

  localparam logic [31:0] SLV_BASE = 32'hFFEF_0200;
  localparam logic [31:0] SLV_MASK = 32'hFFEF_FF00;

  typedef struct packed {
    logic        rw;
    logic [3:0]  slave;
    logic [1:0]  word;
    logic [31:0] wdata;
  } arb_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    GAP
  } mst_state_t;

  function automatic logic [31:0] slv_addr(input logic [3:0] slave, input logic [1:0] word);
    return SLV_BASE | ({28'd0, slave} << 12) | ({30'd0, word} << 4);
  endfunction

endpackage

// File: rtl/arb_cmd_fifo.sv
// Command FIFO; pointers carry an extra wrap bit to separate full from empty.
module arb_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = arb_pkg::arb_cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/arb_bus_master.sv
// Bus initiator: queues commands, requests the bus, performs one single-beat
// transfer per grant and reports read data or a grant timeout.
module arb_bus_master
  import arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned GNT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [3:0]  cmd_slave,
  input  logic [1:0]  cmd_word,
  input  logic [31:0] cmd_wdata,
  output logic        req,
  input  logic        grant,
  output logic [31:0] addr,
  output logic        RW,
  output logic [31:0] DataToSlave,
  input  logic [31:0] DataFromSlave,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  mst_state_t  state, state_d;
  arb_cmd_t    cmd_in, head;
  logic        fifo_full, fifo_empty, push, pop;
  logic [7:0]  wcnt, wcnt_d;
  logic        req_d, rw_d, rsp_valid_d, rsp_err_d;
  logic [31:0] addr_d, wdata_d, rsp_rdata_d;

  assign cmd_in    = '{rw: cmd_rw, slave: cmd_slave, word: cmd_word, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  arb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (arb_cmd_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // addr/RW/DataToSlave double as the holding register for the command in flight
  always_comb begin
    state_d     = state;
    wcnt_d      = wcnt;
    req_d       = req;
    addr_d      = addr;
    rw_d        = RW;
    wdata_d     = DataToSlave;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    pop         = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          req_d   = 1'b1;
          addr_d  = slv_addr(head.slave, head.word);
          rw_d    = head.rw;
          wdata_d = head.wdata;
          wcnt_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (grant) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = RW ? '0 : DataFromSlave;
          state_d     = XFER;
        end else if (({24'd0, wcnt} + 32'd1) >= GNT_TIMEOUT) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = XFER;
        end else begin
          wcnt_d = wcnt + 8'd1;
        end
      end
      XFER: begin
        rw_d    = 1'b0;
        wdata_d = '0;
        state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wcnt        <= '0;
      req         <= 1'b0;
      addr        <= '0;
      RW          <= 1'b0;
      DataToSlave <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state       <= state_d;
      wcnt        <= wcnt_d;
      req         <= req_d;
      addr        <= addr_d;
      RW          <= rw_d;
      DataToSlave <= wdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_arb_bus_master.sv
// Directed self-checking bench for arb_bus_master with a counting slave model.
module tb_arb_bus_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [3:0]  cmd_slave;
  logic [1:0]  cmd_word;
  logic [31:0] cmd_wdata;
  logic        req, grant, RW, rsp_valid, rsp_err;
  logic [31:0] addr, DataToSlave, DataFromSlave, rsp_rdata;

  int checks = 0;
  int failures = 0;

  arb_bus_master #(
    .FIFO_DEPTH  (4),
    .GNT_TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_rw        (cmd_rw),
    .cmd_slave     (cmd_slave),
    .cmd_word      (cmd_word),
    .cmd_wdata     (cmd_wdata),
    .req           (req),
    .grant         (grant),
    .addr          (addr),
    .RW            (RW),
    .DataToSlave   (DataToSlave),
    .DataFromSlave (DataFromSlave),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  // Slave model: read data = {slave id, per-slave read count}
  logic [23:0] rdcnt [16];
  initial for (int i = 0; i < 16; i++) rdcnt[i] = '0;
  assign DataFromSlave = {4'h0, addr[15:12], rdcnt[addr[15:12]]};
  always @(posedge clk)
    if (rst && req && grant && !RW) rdcnt[addr[15:12]] <= rdcnt[addr[15:12]] + 24'd1;

  logic [31:0] rsp_rd_q [$];
  logic        rsp_err_q [$];
  logic [31:0] req_addr_q [$];
  int          run_q [$];
  int          run = 0;
  int          xfers = 0;
  logic        req_prev = 1'b0;
  logic [31:0] last_addr, last_wd;
  logic        last_rw;

  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_rd_q.push_back(rsp_rdata);
      rsp_err_q.push_back(rsp_err);
    end
    if (req && !req_prev) req_addr_q.push_back(addr);
    if (req) run = run + 1;
    else if (req_prev) begin
      run_q.push_back(run);
      run = 0;
    end
    if (req && grant) begin
      xfers = xfers + 1;
      last_addr = addr;
      last_rw = RW;
      last_wd = DataToSlave;
    end
    req_prev = req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic rw, input logic [3:0] slv, input logic [1:0] wd, input logic [31:0] data);
    int n;
    cmd_valid = 1'b1;
    cmd_rw = rw;
    cmd_slave = slv;
    cmd_word = wd;
    cmd_wdata = data;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k;
    k = 0;
    while (rsp_rd_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("rsp_count", 32'(rsp_rd_q.size()), 32'(n));
  endtask

  logic [31:0] exp_addr [6];
  int x0, waited;

  initial begin
    exp_addr[0] = 32'hFFEF_8200; exp_addr[1] = 32'hFFEF_9210;
    exp_addr[2] = 32'hFFEF_A220; exp_addr[3] = 32'hFFEF_B230;
    exp_addr[4] = 32'hFFEF_C200; exp_addr[5] = 32'hFFEF_D210;
    rst = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_slave = '0; cmd_word = '0;
    cmd_wdata = '0; grant = 1'b0;
    tick(); tick();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_rw", 32'(RW), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_dts", DataToSlave, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b1;
    tick();

    // Read slave 3 word 0, grant tied high: exact cycle sequence after acceptance
    grant = 1'b1;
    send(1'b0, 4'd3, 2'd0, 32'hDEAD_BEEF);
    chk("rd_req_wait", 32'(req), 32'd0);
    tick();
    chk("rd_req", 32'(req), 32'd1);
    chk("rd_addr", addr, 32'hFFEF_3200);
    chk("rd_rw", 32'(RW), 32'd0);
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h0300_0000);
    chk("rd_rsp_err", 32'(rsp_err), 32'd0);
    chk("rd_req_low", 32'(req), 32'd0);
    tick();
    chk("rd_rsp_pulse", 32'(rsp_valid), 32'd0);
    tick(); tick();

    // Write slave 2 word 1
    x0 = xfers;
    send(1'b1, 4'd2, 2'd1, 32'h2000_0000);
    tick();
    chk("wr_req", 32'(req), 32'd1);
    chk("wr_addr", addr, 32'hFFEF_2210);
    chk("wr_rw", 32'(RW), 32'd1);
    chk("wr_dts", DataToSlave, 32'h2000_0000);
    tick();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    chk("wr_gap_rw", 32'(RW), 32'd0);
    chk("wr_gap_dts", DataToSlave, 32'd0);
    tick(); tick();
    chk("wr_xfers", 32'(xfers - x0), 32'd1);
    chk("wr_slave_data", last_wd, 32'h2000_0000);

    // Grant delayed: three waiting cycles, transfer on the fourth
    grant = 1'b0;
    x0 = xfers;
    send(1'b0, 4'd5, 2'd3, 32'd0);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("dly_req", 32'(req), 32'd1);
      chk("dly_addr", addr, 32'hFFEF_5230);
      chk("dly_rw", 32'(RW), 32'd0);
      if (c == 3) grant = 1'b1;
      tick();
    end
    grant = 1'b0;
    chk("dly_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("dly_rsp_err", 32'(rsp_err), 32'd0);
    chk("dly_rsp_rdata", rsp_rdata, 32'h0500_0000);
    tick(); tick(); tick();
    chk("dly_xfers", 32'(xfers - x0), 32'd1);

    // Reset pulsed while in REQ, with a second command queued
    send(1'b0, 4'd7, 2'd0, 32'd0);
    send(1'b1, 4'd6, 2'd2, 32'h1234_5678);
    chk("rr_req_before", 32'(req), 32'd1);
    x0 = rsp_rd_q.size();
    #2 rst = 1'b0;
    #1;
    chk("rr_req_async", 32'(req), 32'd0);
    chk("rr_addr_async", addr, 32'd0);
    chk("rr_ready_async", 32'(cmd_ready), 32'd1);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("rr_req_idle", 32'(req), 32'd0);
    chk("rr_no_rsp", 32'(rsp_rd_q.size() - x0), 32'd0);

    // Two reads of slave 1 word 2 against the counting slave
    grant = 1'b1;
    rsp_rd_q.delete(); rsp_err_q.delete();
    send(1'b0, 4'd1, 2'd2, 32'd0);
    send(1'b0, 4'd1, 2'd2, 32'd0);
    wait_rsp(2, 40);
    if (rsp_rd_q.size() >= 2) begin
      chk("rr2_rdata0", rsp_rd_q[0], 32'h0100_0000);
      chk("rr2_rdata1", rsp_rd_q[1], 32'h0100_0001);
      chk("rr2_err0", 32'(rsp_err_q[0]), 32'd0);
      chk("rr2_err1", 32'(rsp_err_q[1]), 32'd0);
    end
    chk("rr2_addr", last_addr, 32'hFFEF_1220);
    tick(); tick(); tick();

    // FIFO fill with grant withheld: all six commands time out in order
    grant = 1'b0;
    rsp_rd_q.delete(); rsp_err_q.delete(); req_addr_q.delete(); run_q.delete();
    send(1'b0, 4'd8, 2'd0, 32'd0);
    tick();
    chk("ff_req_first", 32'(req), 32'd1);
    chk("ff_ready_empty", 32'(cmd_ready), 32'd1);
    for (int i = 1; i < 5; i++) send(1'b0, 4'(8 + i), 2'(i % 4), 32'd0);
    chk("ff_ready_full", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_slave = 4'd13; cmd_word = 2'd1;
    waited = 0;
    while (!cmd_ready && waited < 40) begin
      tick();
      waited++;
    end
    chk("ff_wait_cycles", 32'(waited), 32'd14);
    tick();
    cmd_valid = 1'b0;
    wait_rsp(6, 150);
    for (int i = 0; i < 6; i++) begin
      if (i < rsp_rd_q.size()) begin
        chk("ff_err", 32'(rsp_err_q[i]), 32'd1);
        chk("ff_rdata", rsp_rd_q[i], 32'd0);
      end
      if (i < req_addr_q.size()) chk("ff_order", req_addr_q[i], exp_addr[i]);
      if (i < run_q.size()) chk("ff_req_len", 32'(run_q[i]), 32'd15);
    end
    chk("ff_req_count", 32'(req_addr_q.size()), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
